cl_axi_read_arbiter: RTL
========================

// Module: cl_axi_read_arbiter
// PURPOSE
//  Shares one DDR4 AXI read port (AR/R channels) among NUM_REQUESTERS workgroup controllers.
//  Each requester issues single-beat 512-bit reads (arlen=0). The arbiter:
//   - grants requesters round-robin and forwards AR with arid = requester index;
//   - routes each R beat back to its requester by rid.
//  Sits between the workgroup controllers and the shell DDR AXI master port.
// PARAMETERS
//  NUM_REQUESTERS   4    requesters sharing the port, 2..16
//  ADDR_WIDTH       64   AXI address width
//  DATA_WIDTH       512  AXI read data width
//  ID_WIDTH         16   AXI id width; index sits in LSBs, upper bits 0
//  MAX_OUTSTANDING  8    total accepted-but-unanswered reads allowed, 1..255
// PORTS
//  clock_i       in   1                  clock
//  reset_n_i     in   1                  async active-low reset
//  s_araddr_i    in   N*ADDR_WIDTH       per-requester read address, requester k at [k*ADDR_WIDTH+:ADDR_WIDTH]
//  s_arvalid_i   in   N                  per-requester AR valid
//  s_arready_o   out  N                  per-requester AR ready (one-hot pulse)
//  s_rdata_o     out  DATA_WIDTH         read data, broadcast to all requesters
//  s_rvalid_o    out  N                  per-requester R valid (one-hot)
//  s_rready_i    in   N                  per-requester R ready
//  m_araddr_o    out  ADDR_WIDTH         to DDR
//  m_arid_o      out  ID_WIDTH           to DDR
//  m_arvalid_o   out  1                  to DDR
//  m_arready_i   in   1                  from DDR
//  m_arlen/size/burst_o  out 8/3/2       constant 0 / 3'b110 / 2'b01
//  m_rdata_i     in   DATA_WIDTH         from DDR
//  m_rid_i       in   ID_WIDTH           from DDR
//  m_rvalid_i    in   1                  from DDR
//  m_rready_o    out  1                  to DDR
//  outstanding_o out  8                  current outstanding count
//  rid_error_o   out  1                  sticky: R beat arrived with out-of-range rid
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=SELECT, rr_ptr=0, outstanding=0, rid_error=0.
//   m_arvalid_o=0 and s_arready_o=0 immediately; all registered outputs reset to 0.
//  FSM SELECT: if any s_arvalid_i and outstanding<MAX_OUTSTANDING:
//   - pick first valid index at or after rr_ptr (wrapping N-1 -> 0);
//   - register araddr and index into m_araddr/m_arid; go to ISSUE.
//   Otherwise stay in SELECT.
//  FSM ISSUE: m_arvalid_o=1; address and id are held stable until m_arready_i.
//   On handshake: s_arready_o[grant]=1 for that single cycle; rr_ptr=grant+1 (wrap); outstanding++; go to SELECT.
//   Requester keeps s_arvalid/araddr stable until its s_arready pulse.
//   The arbiter latches the address at grant.
//  Arbitration latency: 1 cycle from s_arvalid seen in SELECT to m_arvalid_o=1.
//   Minimum 2 cycles per AR.
//  R path is combinational, 0 latency:
//   - if m_rid_i<N: s_rvalid_o[m_rid_i]=m_rvalid_i, m_rready_o=s_rready_i[m_rid_i];
//   - else m_rready_o=1 (beat dropped) and rid_error_o set sticky until reset.
//   - s_rdata_o=m_rdata_i always.
//  outstanding decrements on every m_rvalid_i && m_rready_o beat, including dropped ones.
//   AR handshake and R beat in the same cycle: count unchanged.
//   Never underflows: an R beat at 0 holds 0 and sets rid_error.
//  outstanding==MAX_OUTSTANDING: no new grant; FSM holds SELECT until a beat retires.
//  Requester dropping s_arvalid before its pulse is illegal; the latched read is still issued.
//  Mid-operation reset: counters cleared; any in-flight DDR responses after reset are dropped via rid_error path only if rid>=N.
// TESTING
//  1 Reset then single req0 read addr 0x1000 -> m_arvalid high 1 cycle after, araddr=0x1000, arid=0, s_arready[0] pulse on handshake, R beat routed only to s_rvalid[0].
//  2 All 4 requesters valid continuously, m_arready=1 -> grant order 0,1,2,3,0...; each requester granted every 8 cycles.
//  3 MAX_OUTSTANDING=2, no R beats -> third AR not issued, outstanding_o=2. One R beat -> third AR issues next SELECT.
//  4 AR handshake and R beat same cycle at outstanding=3 -> outstanding stays 3.
//  5 m_rid_i=7 with N=4 -> m_rready_o=1, no s_rvalid asserted, rid_error_o=1 held until reset.
//  6 Reset asserted while in ISSUE with m_arready=0 -> m_arvalid_o drops immediately, no s_arready pulse; after release rr_ptr=0, outstanding=0.

Source files
------------

// File: rtl/cl_axi_read_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI read port among several requesters.
// AR requests are serialised through a SELECT/ISSUE FSM; R beats are routed back by rid with zero latency.
module cl_axi_read_arbiter #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clock_i,
    input  logic                                 reset_n_i,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [NUM_REQUESTERS-1:0]            s_arvalid_i,
    output logic [NUM_REQUESTERS-1:0]            s_arready_o,
    output logic [DATA_WIDTH-1:0]                s_rdata_o,
    output logic [NUM_REQUESTERS-1:0]            s_rvalid_o,
    input  logic [NUM_REQUESTERS-1:0]            s_rready_i,
    output logic [ADDR_WIDTH-1:0]                m_araddr_o,
    output logic [ID_WIDTH-1:0]                  m_arid_o,
    output logic                                 m_arvalid_o,
    input  logic                                 m_arready_i,
    output logic [7:0]                           m_arlen_o,
    output logic [2:0]                           m_arsize_o,
    output logic [1:0]                           m_arburst_o,
    input  logic [DATA_WIDTH-1:0]                m_rdata_i,
    input  logic [ID_WIDTH-1:0]                  m_rid_i,
    input  logic                                 m_rvalid_i,
    output logic                                 m_rready_o,
    output logic [7:0]                           outstanding_o,
    output logic                                 rid_error_o
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [0:0] SELECT = 1'b0;
    localparam logic [0:0] ISSUE  = 1'b1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    logic [0:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_p1;
    logic [ADDR_WIDTH-1:0] araddr_p1;
    logic [7:0]            outstanding;
    logic                  rid_error;

    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  rid_in_range;
    logic [IDX_W-1:0]      rid_idx;

    // A simultaneous AR accept and R retire cancel out; the count never wraps below zero.
    function automatic logic [7:0] next_count(input logic [7:0] cnt, input logic inc, input logic dec);
        if (inc && !dec)
            return cnt + 8'd1;
        if (dec && !inc && (cnt != 8'd0))
            return cnt - 8'd1;
        return cnt;
    endfunction

    always_comb begin : rr_pick
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQUESTERS)
                cand = cand - NUM_REQUESTERS;
            if (!pick_found && s_arvalid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign pick_addr    = s_araddr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_hs        = (state == ISSUE) && m_arready_i;
    assign rid_in_range = (m_rid_i < ID_WIDTH'(NUM_REQUESTERS));
    assign rid_idx      = m_rid_i[IDX_W-1:0];
    assign r_hs         = m_rvalid_i && m_rready_o;

    always_comb begin
        s_arready_o = '0;
        if (ar_hs)
            s_arready_o[grant_p1] = 1'b1;
    end

    // Out-of-range ids are accepted and dropped so the DDR port can never stall on them.
    always_comb begin
        s_rvalid_o = '0;
        m_rready_o = 1'b1;
        if (rid_in_range) begin
            s_rvalid_o[rid_idx] = m_rvalid_i;
            m_rready_o          = s_rready_i[rid_idx];
        end
    end

    // Stage p1: granted request held on the master AR channel until accepted.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= SELECT;
            rr_ptr      <= '0;
            grant_p1    <= '0;
            araddr_p1   <= '0;
            outstanding <= '0;
            rid_error   <= 1'b0;
        end else begin
            outstanding <= next_count(outstanding, ar_hs, r_hs);
            if ((m_rvalid_i && !rid_in_range) || (r_hs && !ar_hs && (outstanding == 8'd0)))
                rid_error <= 1'b1;
            if (state == SELECT) begin
                if (pick_found && (outstanding < MAX_CNT)) begin
                    grant_p1  <= pick_idx;
                    araddr_p1 <= pick_addr;
                    state     <= ISSUE;
                end
            end else if (m_arready_i) begin
                rr_ptr <= (grant_p1 == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_p1 + 1'b1;
                state  <= SELECT;
            end
        end
    end

    assign m_araddr_o    = araddr_p1;
    assign m_arid_o      = ID_WIDTH'(grant_p1);
    assign m_arvalid_o   = (state == ISSUE);
    assign m_arlen_o     = 8'd0;
    assign m_arsize_o    = 3'b110;
    assign m_arburst_o   = 2'b01;
    assign s_rdata_o     = m_rdata_i;
    assign outstanding_o = outstanding;
    assign rid_error_o   = rid_error;

endmodule
